// File: rtl/complex_mag_sq_avg.sv
// Streaming |x|^2 = i^2 + q^2 over a 3-stage pipeline, plus a block average of the
// valid results over 2^LOG2_AVG samples with synchronous window restart.
module complex_mag_sq_avg #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LOG2_AVG = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] i,
    input  logic signed [WIDTH-1:0] q,
    input  logic                    input_valid,
    input  logic                    avg_clear,
    output logic [2*WIDTH-1:0]      mag_sq,
    output logic                    mag_sq_valid,
    output logic [2*WIDTH-1:0]      avg_pow,
    output logic                    avg_valid,
    output logic [LOG2_AVG-1:0]     avg_count
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + LOG2_AVG;
    localparam logic [LOG2_AVG-1:0] LastCount = {LOG2_AVG{1'b1}};

    // Stage 1: registered inputs
    logic signed [WIDTH-1:0] i_s1_q, q_s1_q;
    logic                    valid_s1_q;

    // Stage 2: registered squares
    logic signed [PW-1:0] i_ext, q_ext;
    logic signed [PW-1:0] ii_d, qq_d;
    logic signed [PW-1:0] ii_s2_q, qq_s2_q;
    logic                 valid_s2_q;

    // Stage 3 and averaging state
    logic [PW-1:0]       ii_u, qq_u;
    logic [PW-1:0]       mag_d, mag_q;
    logic                mag_valid_d, mag_valid_q;
    logic [AW-1:0]       acc_sum;
    logic [AW-1:0]       acc_d, acc_q;
    logic [LOG2_AVG-1:0] count_d, count_q;
    logic [PW-1:0]       avg_pow_d, avg_pow_q;
    logic                avg_valid_d, avg_valid_q;
    logic                window_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_s1_q     <= '0;
            q_s1_q     <= '0;
            valid_s1_q <= 1'b0;
        end else if (enable) begin
            i_s1_q     <= i;
            q_s1_q     <= q;
            valid_s1_q <= input_valid;
        end
    end

    always_comb begin
        i_ext = {{WIDTH{i_s1_q[WIDTH-1]}}, i_s1_q};
        q_ext = {{WIDTH{q_s1_q[WIDTH-1]}}, q_s1_q};
        ii_d  = i_ext * i_ext;
        qq_d  = q_ext * q_ext;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ii_s2_q    <= '0;
            qq_s2_q    <= '0;
            valid_s2_q <= 1'b0;
        end else if (enable) begin
            ii_s2_q    <= ii_d;
            qq_s2_q    <= qq_d;
            valid_s2_q <= valid_s1_q;
        end
    end

    // Both squares are non-negative, so their sum (at most 2^(PW-1)) fits unsigned in PW bits.
    always_comb begin
        ii_u    = ii_s2_q;
        qq_u    = qq_s2_q;
        acc_sum = acc_q + {{LOG2_AVG{1'b0}}, ii_u + qq_u};
    end

    always_comb begin
        mag_d       = mag_q;
        mag_valid_d = 1'b0;
        acc_d       = acc_q;
        count_d     = count_q;
        avg_pow_d   = avg_pow_q;
        avg_valid_d = 1'b0;
        window_done = valid_s2_q && (count_q == LastCount);
        if (enable) begin
            mag_valid_d = valid_s2_q;
            if (valid_s2_q) begin
                mag_d = ii_u + qq_u;
            end
            // A clear excludes the result loading on this edge and suppresses completion.
            if (avg_clear) begin
                acc_d   = '0;
                count_d = '0;
            end else if (window_done) begin
                avg_pow_d   = acc_sum[AW-1:LOG2_AVG];
                avg_valid_d = 1'b1;
                acc_d       = '0;
                count_d     = '0;
            end else if (valid_s2_q) begin
                acc_d   = acc_sum;
                count_d = count_q + LOG2_AVG'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mag_q       <= '0;
            mag_valid_q <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            avg_pow_q   <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            mag_q       <= mag_d;
            mag_valid_q <= mag_valid_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            avg_pow_q   <= avg_pow_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign mag_sq       = mag_q;
    assign mag_sq_valid = mag_valid_q;
    assign avg_pow      = avg_pow_q;
    assign avg_valid    = avg_valid_q;
    assign avg_count    = count_q;

endmodule

// File: tb/tb_complex_mag_sq_avg.sv
// Bench for complex_mag_sq_avg (WIDTH=16, LOG2_AVG=2): directed literal checks plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_complex_mag_sq_avg;

    localparam int unsigned W = 16;
    localparam int unsigned L = 2;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic input_valid = 1'b0;
    logic avg_clear = 1'b0;
    logic signed [W-1:0] i = '0;
    logic signed [W-1:0] q = '0;
    logic [2*W-1:0] mag_sq, avg_pow;
    logic mag_sq_valid, avg_valid;
    logic [L-1:0] avg_count;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    always #5 clock = ~clock;

    complex_mag_sq_avg #(.WIDTH(W), .LOG2_AVG(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .i            (i),
        .q            (q),
        .input_valid  (input_valid),
        .avg_clear    (avg_clear),
        .mag_sq       (mag_sq),
        .mag_sq_valid (mag_sq_valid),
        .avg_pow      (avg_pow),
        .avg_valid    (avg_valid),
        .avg_count    (avg_count)
    );

    // Reference model: a sample appears at the output two enabled edges after S1 takes it.
    typedef struct {
        int si;
        int sq;
        bit v;
    } samp_t;

    samp_t  pipe[$];
    longint win_sum = 0;
    int     win_cnt = 0;
    longint exp_mag = 0;
    bit     exp_mag_valid = 1'b0;
    longint exp_avg = 0;
    bit     exp_avg_valid = 1'b0;
    int     exp_count = 0;

    initial begin
        samp_t s, n;
        longint r;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                pipe.delete();
                s.si = 0; s.sq = 0; s.v = 1'b0;
                pipe.push_back(s);
                pipe.push_back(s);
                win_sum = 0; win_cnt = 0;
                exp_mag = 0; exp_mag_valid = 1'b0;
                exp_avg = 0; exp_avg_valid = 1'b0;
                exp_count = 0;
            end else if (enable) begin
                n.si = int'(i); n.sq = int'(q); n.v = input_valid;
                pipe.push_back(n);
                s = pipe.pop_front();
                r = longint'(s.si) * s.si + longint'(s.sq) * s.sq;
                exp_mag_valid = s.v;
                if (s.v) exp_mag = r;
                exp_avg_valid = 1'b0;
                if (avg_clear) begin
                    win_sum = 0; win_cnt = 0;
                end else if (s.v) begin
                    win_sum += r;
                    win_cnt++;
                    if (win_cnt == N) begin
                        exp_avg = win_sum / N;
                        exp_avg_valid = 1'b1;
                        win_sum = 0; win_cnt = 0;
                    end
                end
                exp_count = win_cnt;
            end else begin
                exp_mag_valid = 1'b0;
                exp_avg_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input int ii, input int qq, input bit v, input bit clr);
        logic [31:0] a, b;
        a = ii; b = qq;
        i = a[W-1:0];
        q = b[W-1:0];
        input_valid = v;
        avg_clear = clr;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mag_sq"}, mag_sq, 0);
        check({tag, "_mag_sq_valid"}, mag_sq_valid, 0);
        check({tag, "_avg_pow"}, avg_pow, 0);
        check({tag, "_avg_valid"}, avg_valid, 0);
        check({tag, "_avg_count"}, avg_count, 0);
    endtask

    initial begin
        fork
            begin : compare
                while (!done) begin
                    @(negedge clock);
                    if (!done) begin
                        check("mag_sq_valid", mag_sq_valid, exp_mag_valid);
                        if (exp_mag_valid) check("mag_sq", mag_sq, exp_mag);
                        check("avg_valid", avg_valid, exp_avg_valid);
                        check("avg_pow", avg_pow, exp_avg);
                        check("avg_count", avg_count, exp_count);
                    end
                end
            end
            begin : stimulus
                int cexp[4];
                int sent, seen, stall;
                logic [31:0] rnd;

                repeat (2) @(negedge clock);
                check_zero("reset");
                reset = 1'b0;
                enable = 1'b1;
                repeat (5) begin
                    @(negedge clock);
                    check("idle_mag_valid", mag_sq_valid, 0);
                    check("idle_avg_valid", avg_valid, 0);
                end

                // Latency: one (3,4) sample
                for (int k = 0; k < 6; k++) begin
                    @(negedge clock);
                    if (k == 2 || k == 4) check("lat_valid_off", mag_sq_valid, 0);
                    if (k == 3) begin
                        check("lat_valid_on", mag_sq_valid, 1);
                        check("lat_mag_25", mag_sq, 25);
                    end
                    if (k == 0) drive(3, 4, 1, 0); else drive(0, 0, 0, 0);
                end
                @(negedge clock); drive(0, 0, 0, 1);
                @(negedge clock); drive(0, 0, 0, 0);

                // Averaging: 1,4,9,16 -> sum 30, avg 7
                cexp = '{1, 2, 3, 0};
                for (int k = 0; k < 8; k++) begin
                    @(negedge clock);
                    if (k >= 3 && k <= 6) check("avg_count_step", avg_count, cexp[k-3]);
                    if (k == 5) check("avg_valid_early", avg_valid, 0);
                    if (k == 6) begin
                        check("avg_valid_4th", avg_valid, 1);
                        check("avg_mag_valid_4th", mag_sq_valid, 1);
                        check("avg_pow_7", avg_pow, 7);
                    end
                    if (k < 4) drive(k + 1, 0, 1, 0); else drive(0, 0, 0, 0);
                end

                // Extremes
                for (int k = 0; k < 6; k++) begin
                    @(negedge clock);
                    if (k == 3) check("ext_min_min", mag_sq, 64'h8000_0000);
                    if (k == 4) check("ext_max_min", mag_sq, 64'h7FFF_0001);
                    if (k == 0) drive(-32768, -32768, 1, 0);
                    else if (k == 1) drive(32767, -32768, 1, 0);
                    else drive(0, 0, 0, 0);
                end
                @(negedge clock); drive(0, 0, 0, 1);
                @(negedge clock); drive(0, 0, 0, 0);

                // Continuous (3,4) stream
                for (int k = 0; k < 15; k++) begin
                    @(negedge clock);
                    if (k == 6 || k == 10) begin
                        check("stream_avg_valid", avg_valid, 1);
                        check("stream_avg_25", avg_pow, 25);
                    end
                    if (k < 12) drive(3, 4, 1, 0); else drive(0, 0, 0, 0);
                end

                // Clear on the edge that loads the 4th sample, then a fresh window 1..4
                for (int k = 0; k < 12; k++) begin
                    @(negedge clock);
                    if (k == 5) check("clr_count_pre", avg_count, 3);
                    if (k == 6) begin
                        check("clr_no_avg_valid", avg_valid, 0);
                        check("clr_count_zero", avg_count, 0);
                        check("clr_avg_hold", avg_pow, 25);
                        check("clr_mag_out", mag_sq, 25);
                    end
                    if (k == 10) begin
                        check("clr_next_valid", avg_valid, 1);
                        check("clr_next_avg_7", avg_pow, 7);
                    end
                    if (k < 4) drive(5, 0, 1, 0);
                    else if (k < 8) drive(k - 3, 0, 1, k == 5);
                    else drive(0, 0, 0, 0);
                end

                // Stall: enable drops for 2 cycles at random points
                sent = 0; seen = 0; stall = 0;
                for (int k = 0; k < 60; k++) begin
                    @(negedge clock);
                    if (mag_sq_valid) seen++;
                    if (stall > 0) begin
                        enable = 1'b0;
                        stall--;
                    end else begin
                        enable = 1'b1;
                        if ($urandom_range(0, 5) == 0) stall = 2;
                    end
                    drive(3, 4, k < 40, 0);
                    if (enable && input_valid) sent++;
                end
                enable = 1'b1;
                drive(0, 0, 0, 0);
                repeat (5) begin
                    @(negedge clock);
                    if (mag_sq_valid) seen++;
                end
                check("stall_pulse_count", seen, sent);

                // Random traffic with an asynchronous reset in the middle
                for (int k = 0; k < 1600; k++) begin
                    if (k == 700) begin
                        @(posedge clock);
                        #2 reset = 1'b1;
                        #1 check_zero("async_rst");
                        @(negedge clock);
                        reset = 1'b0;
                        enable = 1'b1;
                        drive(0, 0, 0, 0);
                        repeat (6) begin
                            @(negedge clock);
                            check("post_rst_mag_valid", mag_sq_valid, 0);
                            check("post_rst_avg_valid", avg_valid, 0);
                        end
                    end
                    @(negedge clock);
                    rnd = $urandom;
                    drive(int'($signed(rnd[15:0])), int'($signed(rnd[31:16])),
                          $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 3);
                    enable = $urandom_range(0, 99) < 85;
                end
                enable = 1'b1;
                drive(0, 0, 0, 0);
                repeat (5) @(negedge clock);
                done = 1'b1;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/complex_mag_sq_avg.md
Name: complex_mag_sq_avg

Overview:
Parametrised successor to the fixed 16-bit magnitude-squared block. It computes |x|^2 = i^2 + q^2 on a streaming complex input of configurable width through a 3-stage pipeline. It also produces a block-averaged power over 2^LOG2_AVG valid samples, with a synchronous window restart. It sits after DDC/filter stages and feeds power detectors, AGC and packet-detect thresholds.

Parameters:
- WIDTH, 16, signed bit width of i and q.
- LOG2_AVG, 4, log2 of the averaging window length N = 2^LOG2_AVG. Range 1..16.

Ports:
- clock, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- enable, input, 1, clock enable; low freezes the block.
- i, input, WIDTH, signed in-phase sample.
- q, input, WIDTH, signed quadrature sample.
- input_valid, input, 1, i/q qualifier.
- avg_clear, input, 1, synchronous restart of the averaging window.
- mag_sq, output, 2*WIDTH, unsigned instantaneous i^2+q^2.
- mag_sq_valid, output, 1, one-cycle pulse per result.
- avg_pow, output, 2*WIDTH, unsigned window average: floor(sum/N).
- avg_valid, output, 1, one-cycle pulse per completed window.
- avg_count, output, LOG2_AVG, number of samples accumulated in the current window.

Behaviour:
- Interface: one clock named clock; reset is asynchronous and active-high, named reset.
- Reset clears all pipeline data and valid registers, the accumulator and the counter. All outputs read 0 during and after reset until the first result.
- Pipeline, with enable high:
  - S1 registers i, q and input_valid.
  - S2 registers the signed products i*i and q*q, each 2*WIDTH bits.
  - S3 registers their unsigned sum into mag_sq.
- Latency: mag_sq_valid is asserted 3 cycles after input_valid is sampled. Throughput is 1 sample per cycle; there is no backpressure.
- Width: the maximum result is 2*(2^(WIDTH-1))^2 = 2^(2*WIDTH-1), so it always fits in 2*WIDTH bits. No saturation or truncation.
- Invalid samples still flow through the data path; only the valid flags gate downstream effects. mag_sq holds its last value when mag_sq_valid is 0.
- enable low:
  - All data registers, S1/S2 valid flags, the accumulator and avg_count hold.
  - The mag_sq_valid and avg_valid registers load 0, so each result pulses exactly once.
  - The pipeline resumes on the first enable-high edge with no loss or duplication.
- Accumulator: width 2*WIDTH+LOG2_AVG, so it cannot overflow.
  - On each edge where S3 loads a valid result, acc += that result and avg_count increments.
  - When the loaded result is the N-th of the window, on that same edge:
    - avg_pow <= (acc + result) >> LOG2_AVG, keeping the low 2*WIDTH bits, which is exact since avg <= max.
    - avg_valid <= 1, so it pulses in the same cycle as that sample's mag_sq_valid.
    - acc <= 0 and avg_count <= 0.
- avg_clear, sampled when enable is high:
  - acc <= 0 and avg_count <= 0.
  - The S3 result loaded on the same edge is excluded from the new window, but is still output on mag_sq.
  - If a window would complete on that edge, clear wins: no avg_valid pulse and avg_pow holds.
  - The pipeline is not flushed.
- avg_count wraps N-1 -> 0 only through window completion. It never reads N.
- Reset asserted mid-window discards the partial sum and any in-flight samples.

Test Plan:
- Reset: assert reset asynchronously mid-stream -> all outputs 0 immediately; after release with no input, mag_sq_valid and avg_valid stay 0.
- Latency/arithmetic, WIDTH=16: i=3, q=4 valid for one cycle -> mag_sq=25 with mag_sq_valid exactly 3 cycles later, one cycle wide.
- Extremes: i=q=-32768 -> mag_sq=0x80000000; i=32767, q=-32768 -> 0x7FFF0001.
- Averaging, LOG2_AVG=2:
  - Samples (i,q) = (1,0), (2,0), (3,0), (4,0) -> sum 30; avg_pow=7 and avg_valid pulse coincident with the 4th mag_sq_valid.
  - avg_count steps 1, 2, 3, 0.
  - Continuous stream of (3,4) -> avg_pow=25 every 4 results.
- Stall: stream (3,4) with enable toggled low for 2 cycles at random points -> exactly one mag_sq_valid per input, values unchanged, no duplicates.
- Clear: LOG2_AVG=2; assert avg_clear on the edge loading the 4th sample -> no avg_valid; the next 4 valid samples complete a window with the correct average.
